// File: rtl/sram_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : sram_axi_bridge
//  Purpose  : Merges the core's instruction (read-only) and data (read/write)
//             sram-like ports onto one single-beat 32-bit AXI3 master.
//             One outstanding transaction; data port wins ties.
//  Revision : 1.0  initial release
// ============================================================================
module sram_axi_bridge (
  input  logic        clk,
  input  logic        resetn,
  // instruction port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address / data
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address / data / response
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  state_t      state_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic        arvalid_q;
  logic        rready_q;
  logic [31:0] awaddr_q;
  logic [2:0]  awsize_q;
  logic        awvalid_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        owner_data_q;
  logic        inst_data_ok_q;
  logic        data_data_ok_q;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;

  // Each write channel counts as finished once it has handshaken, either in
  // an earlier cycle or right now, so same-cycle handshakes move on at once.
  logic w_aw_fin;
  logic w_w_fin;
  assign w_aw_fin = aw_done_q | (awvalid_q & awready);
  assign w_w_fin  = w_done_q  | (wvalid_q  & wready);

  // The read ID is not needed with a single outstanding transaction.
  logic unused_rid;
  assign unused_rid = ^rid;

  // Acceptance is combinational in IDLE; the data port has priority.
  assign data_addr_ok = resetn && (state_q == S_IDLE) && data_req;
  assign inst_addr_ok = resetn && (state_q == S_IDLE) && inst_req && !data_req;

  assign arid         = arid_q;
  assign araddr       = araddr_q;
  assign arsize       = arsize_q;
  assign arvalid      = arvalid_q;
  assign rready       = rready_q;
  assign awaddr       = awaddr_q;
  assign awsize       = awsize_q;
  assign awvalid      = awvalid_q;
  assign wdata        = wdata_q;
  assign wstrb        = wstrb_q;
  assign wvalid       = wvalid_q;
  assign bready       = bready_q;
  assign inst_data_ok = inst_data_ok_q;
  assign data_data_ok = data_data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;

  // Transaction FSM with all bus-facing outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      arid_q         <= 4'd0;
      araddr_q       <= 32'd0;
      arsize_q       <= 3'd0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      awaddr_q       <= 32'd0;
      awsize_q       <= 3'd0;
      awvalid_q      <= 1'b0;
      wdata_q        <= 32'd0;
      wstrb_q        <= 4'd0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      owner_data_q   <= 1'b0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      inst_rdata_q   <= 32'd0;
      data_rdata_q   <= 32'd0;
    end else begin
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (data_req) begin
            if (data_wr) begin
              awaddr_q  <= data_addr;
              awsize_q  <= {1'b0, data_size};
              wdata_q   <= data_wdata;
              wstrb_q   <= data_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= S_WR_REQ;
            end else begin
              araddr_q     <= data_addr;
              arsize_q     <= {1'b0, data_size};
              arid_q       <= 4'd1;
              arvalid_q    <= 1'b1;
              owner_data_q <= 1'b1;
              state_q      <= S_RD_ADDR;
            end
          end else if (inst_req) begin
            araddr_q     <= inst_addr;
            arsize_q     <= 3'b010;
            arid_q       <= 4'd0;
            arvalid_q    <= 1'b1;
            owner_data_q <= 1'b0;
            state_q      <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            if (owner_data_q) begin
              data_rdata_q   <= rdata;
              data_data_ok_q <= 1'b1;
            end else begin
              inst_rdata_q   <= rdata;
              inst_data_ok_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        end
        S_WR_REQ: begin
          if (awvalid_q && awready) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (wvalid_q && wready) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            bready_q       <= 1'b0;
            data_data_ok_q <= 1'b1;
            state_q        <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_sram_axi_bridge
//  Purpose  : Directed self-checking bench for sram_axi_bridge with a
//             delay-programmable AXI slave and a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AXI slave model ----------------
  int ar_wait, r_wait, aw_wait, w_wait, b_wait;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  int ar_hs_n, aw_hs_n, w_hs_n, b_hs_n;
  logic r_pend, b_pend, aw_got, w_got;
  logic [31:0] r_addr;
  logic ar_pending_q;
  logic [31:0] prev_araddr;
  logic ar_unstable;
  logic aw_hs, w_hs;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h1FC0_0000) ? 32'h3C08_BFC0 : (a ^ 32'h5A5A_A5A5);
  endfunction

  assign arready = arvalid && (ar_cnt >= ar_wait);
  assign rvalid  = r_pend && (r_cnt >= r_wait);
  assign rdata   = mem_word(r_addr);
  assign rid     = 4'hA;
  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid && (w_cnt >= w_wait);
  assign bvalid  = b_pend && (b_cnt >= b_wait);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      ar_hs_n <= 0; aw_hs_n <= 0; w_hs_n <= 0; b_hs_n <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      r_addr <= 32'd0; ar_pending_q <= 1'b0; prev_araddr <= 32'd0; ar_unstable <= 1'b0;
    end else begin
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_pending_q <= arvalid && !arready;
      prev_araddr  <= araddr;
      if (ar_pending_q && araddr != prev_araddr) ar_unstable <= 1'b1;
      if (arvalid && arready) begin
        r_pend <= 1'b1; r_cnt <= 0; r_addr <= araddr; ar_hs_n <= ar_hs_n + 1;
      end else if (r_pend) begin
        if (rvalid && rready) r_pend <= 1'b0;
        else r_cnt <= r_cnt + 1;
      end
      if (aw_hs) aw_hs_n <= aw_hs_n + 1;
      if (w_hs)  w_hs_n  <= w_hs_n + 1;
      if (b_pend) begin
        if (bvalid && bready) begin b_pend <= 1'b0; b_hs_n <= b_hs_n + 1; end
        else b_cnt <= b_cnt + 1;
      end else if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard and checking ----------------
  typedef struct packed {
    logic        is_data;
    logic        chk;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  int errors;
  int checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic is_data, input logic chk, input logic [31:0] d);
    exp_t e;
    e.is_data = is_data; e.chk = chk; e.rdata = d;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_ok(output int n);
    n = 0;
    while (!(inst_data_ok || data_data_ok) && n < 60) begin
      tick(); n++;
    end
    check("data_ok_seen", 32'(inst_data_ok | data_data_ok), 32'd1);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_data_ok"}, 32'(data_data_ok), 32'(e.is_data));
      check({tag, "_inst_ok"}, 32'(inst_data_ok), 32'(!e.is_data));
      if (e.chk) check({tag, "_rdata"}, e.is_data ? data_rdata : inst_rdata, e.rdata);
    end
  endtask

  task automatic no_pulse(input string tag);
    check(tag, 32'({inst_data_ok, data_data_ok}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int a0, aw0, w0, b0;
    errors = 0; checks = 0;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    resetn = 1'b0;
    inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
    check("rst_oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_rdata", inst_rdata | data_rdata, 32'd0);
    resetn = 1'b1;
    tick();

    // 1: instruction read, zero-wait slave
    inst_req = 1'b1; inst_addr = 32'h1FC0_0000;
    #1;
    check("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    push(1'b0, 1'b1, 32'h3C08_BFC0);
    tick(); inst_req = 1'b0;
    check("t1_arvalid", 32'(arvalid), 32'd1);
    check("t1_arid", 32'(arid), 32'd0);
    check("t1_arsize", 32'(arsize), 32'd2);
    check("t1_araddr", araddr, 32'h1FC0_0000);
    wait_ok(n);
    check("t1_latency", 32'(n), 32'd2);
    sb_check("t1");
    tick(); no_pulse("t1_single_pulse");

    // 2: simultaneous requests, data read wins
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h0000_1004;
    #1;
    check("t2_data_addr_ok", 32'(data_addr_ok), 32'd1);
    check("t2_inst_blocked", 32'(inst_addr_ok), 32'd0);
    push(1'b1, 1'b1, mem_word(32'h0000_1004));
    tick(); data_req = 1'b0;
    check("t2_arid", 32'(arid), 32'd1);
    check("t2_arsize", 32'(arsize), 32'd1);
    check("t2_araddr", araddr, 32'h0000_1004);
    check("t2_inst_busy", 32'(inst_addr_ok), 32'd0);
    wait_ok(n);
    sb_check("t2d");
    check("t2_inst_accept_on_ok", 32'(inst_addr_ok), 32'd1);
    push(1'b0, 1'b1, mem_word(32'hBFC0_0010));
    tick(); inst_req = 1'b0;
    check("t2_inst_arid", 32'(arid), 32'd0);
    wait_ok(n);
    check("t2_inst_latency", 32'(n), 32'd2);
    sb_check("t2i");
    tick();

    // 3: word write, awready two cycles before wready
    aw_wait = 1; w_wait = 3;
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_2000;
    data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF;
    #1;
    check("t3_addr_ok", 32'(data_addr_ok), 32'd1);
    push(1'b1, 1'b0, 32'd0);
    tick(); data_req = 1'b0; data_wdata = 32'd0;
    check("t3_valids", 32'({awvalid, wvalid}), 32'd3);
    check("t3_awaddr", awaddr, 32'h0000_2000);
    check("t3_awsize", 32'(awsize), 32'd2);
    check("t3_wdata", wdata, 32'hDEAD_BEEF);
    check("t3_wstrb", 32'(wstrb), 32'hF);
    tick(); tick();
    check("t3_aw_dropped_w_held", 32'({awvalid, wvalid}), 32'd1);
    check("t3_wdata_stable", wdata, 32'hDEAD_BEEF);
    tick();
    check("t3_wvalid_c4", 32'(wvalid), 32'd1);
    wait_ok(n);
    check("t3_latency", 32'(n), 32'd2);
    sb_check("t3");
    check("t3_hs_counts", 32'({4'(aw_hs_n - aw0), 4'(w_hs_n - w0), 4'(b_hs_n - b0)}), 32'h111);
    tick(); no_pulse("t3_single_pulse");

    // 4: byte write with same-cycle awready/wready
    aw_wait = 0; w_wait = 0;
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h0000_2002;
    data_wdata = 32'h00AB_0000; data_wstrb = 4'h4;
    #1;
    check("t4_addr_ok", 32'(data_addr_ok), 32'd1);
    push(1'b1, 1'b0, 32'd0);
    tick(); data_req = 1'b0;
    check("t4_wstrb", 32'(wstrb), 32'h4);
    check("t4_awsize", 32'(awsize), 32'd0);
    check("t4_awaddr", awaddr, 32'h0000_2002);
    tick();
    check("t4_in_resp", 32'({awvalid, wvalid, bready}), 32'd1);
    wait_ok(n);
    check("t4_latency", 32'(n), 32'd1);
    sb_check("t4");
    check("t4_hs_counts", 32'({4'(aw_hs_n - aw0), 4'(w_hs_n - w0), 4'(b_hs_n - b0)}), 32'h111);
    tick(); no_pulse("t4_single_pulse");

    // 5: read with arready delayed 5 cycles and rvalid 3 more
    ar_wait = 5; r_wait = 3;
    a0 = ar_hs_n;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_3008;
    #1;
    push(1'b1, 1'b1, mem_word(32'h0000_3008));
    tick(); data_req = 1'b0; data_addr = 32'd0;
    check("t5_araddr", araddr, 32'h0000_3008);
    wait_ok(n);
    check("t5_latency", 32'(n), 32'd10);
    sb_check("t5");
    check("t5_araddr_stable", 32'(ar_unstable), 32'd0);
    check("t5_ar_hs", 32'(ar_hs_n - a0), 32'd1);
    tick(); no_pulse("t5_single_pulse");

    // 6: reset while waiting for read data
    ar_wait = 0; r_wait = 10;
    inst_req = 1'b1; inst_addr = 32'h1FC0_0000;
    #1;
    push(1'b0, 1'b1, 32'h3C08_BFC0);
    tick(); inst_req = 1'b0;
    tick();
    check("t6_rready", 32'(rready), 32'd1);
    tick();
    resetn = 1'b0;
    #1;
    check("t6_rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
    check("t6_rst_rdata", inst_rdata | data_rdata, 32'd0);
    check("t6_rst_addr", araddr | awaddr, 32'd0);
    no_pulse("t6_rst_no_ok");
    sb.delete();
    tick(); no_pulse("t6_rst_no_ok2");
    resetn = 1'b1;
    tick(); no_pulse("t6_post_rst_no_ok");
    r_wait = 0;
    inst_req = 1'b1; inst_addr = 32'h1FC0_0000;
    #1;
    check("t6_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    push(1'b0, 1'b1, 32'h3C08_BFC0);
    tick(); inst_req = 1'b0;
    wait_ok(n);
    check("t6_latency", 32'(n), 32'd2);
    sb_check("t6");
    tick(); no_pulse("t6_single_pulse");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
